// File: rtl/oldest_finder_pipe_pkg.sv
// Shared constants and helpers for the oldest-entry finder tree.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default reservation-station sizes, the merge-node pick encoding,
// and a popcount helper that turns PIPE_MASK into the pipeline latency.
// The optional one-hot grant output is switched by OLDEST_FINDER_ONEHOT_EN.
package oldest_finder_pipe_pkg;

   localparam int DEF_ENTNUM = 8;
   localparam int DEF_VALLEN = 8;

   // Which input a merge node forwards.
   typedef enum logic [1:0] {
      PICK_NONE = 2'd0,
      PICK_A    = 2'd1,
      PICK_B    = 2'd2
   } pick_e;

   // Number of register banks implied by a pipeline mask over 'levels' tree levels.
   function automatic int mask_popcount(input int unsigned mask, input int levels);
      int cnt;
      cnt = 0;
      for (int i = 0; i < levels; i++) begin
         if (((mask >> i) & 32'd1) != 32'd0) cnt++;
      end
      return cnt;
   endfunction

endpackage

// File: rtl/oldest_merge2.sv
// Two-input merge node of the oldest-finder tree: forwards the requesting input with the smaller key.
// Latency: combinational.
// Backpressure: none.
//
// Ports: req_a/ent_a/val_a = lower-index input, req_b/ent_b/val_b = higher-index input,
//        req/ent/val = merged result (all zero when neither input requests).
module oldest_merge2
   import oldest_finder_pipe_pkg::*;
#(
   parameter int ENTLEN = 3,
   parameter int VALLEN = 8
) (
   input  logic              req_a,
   input  logic [ENTLEN-1:0] ent_a,
   input  logic [VALLEN-1:0] val_a,
   input  logic              req_b,
   input  logic [ENTLEN-1:0] ent_b,
   input  logic [VALLEN-1:0] val_b,
   output logic              req,
   output logic [ENTLEN-1:0] ent,
   output logic [VALLEN-1:0] val
);

   pick_e pick;

   // B wins only on a strictly smaller key, so equal keys resolve to the lower index.
   always_comb begin
      pick = PICK_NONE;
      if (req_a && req_b) begin
         pick = (val_b < val_a) ? PICK_B : PICK_A;
      end else if (req_a) begin
         pick = PICK_A;
      end else if (req_b) begin
         pick = PICK_B;
      end
   end

   always_comb begin
      req = req_a | req_b;
      ent = '0;
      val = '0;
      case (pick)
         PICK_A: begin
            ent = ent_a;
            val = val_a;
         end
         PICK_B: begin
            ent = ent_b;
            val = val_b;
         end
         default: begin
            ent = '0;
            val = '0;
         end
      endcase
   end

endmodule

// File: rtl/oldest_finder_pipe.sv
// Parametrised N-entry oldest-entry selector: balanced tree of merge nodes, optional register banks per level.
// Latency: popcount(PIPE_MASK) cycles from in_valid to out_valid (0 = fully combinational).
// Backpressure: stall freezes every bank (inputs offered during stall are dropped); flush kills all in-flight results.
//
// Ports: clk, reset (sync, active-high), in_valid/stall/flush controls, reqvec (per-entry request),
//        valvec (entry i key at [i*VALLEN +: VALLEN]); out_valid, found, oldent, oldval results.
// Build option: define OLDEST_FINDER_ONEHOT_EN to add oldgrant[ENTNUM-1:0], the one-hot of oldent.
// ENTLEN must equal log2(ENTNUM); ENTNUM is a power of two in 2..64.
module oldest_finder_pipe
   import oldest_finder_pipe_pkg::*;
#(
   parameter int          ENTNUM    = DEF_ENTNUM,
   parameter int          ENTLEN    = 3,
   parameter int          VALLEN    = DEF_VALLEN,
   parameter int unsigned PIPE_MASK = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic                     stall,
   input  logic                     flush,
   input  logic [ENTNUM-1:0]        reqvec,
   input  logic [ENTNUM*VALLEN-1:0] valvec,
   output logic                     out_valid,
   output logic                     found,
   output logic [ENTLEN-1:0]        oldent,
   output logic [VALLEN-1:0]        oldval
`ifdef OLDEST_FINDER_ONEHOT_EN
   ,
   output logic [ENTNUM-1:0]        oldgrant
`endif
);

   localparam int LEVELS = ENTLEN;
   localparam int LAT    = mask_popcount(PIPE_MASK, LEVELS);

   // Level k halves the candidate count; each level owns its own result arrays,
   // and level k reads level k-1's results (or the raw inputs at k = 0).
   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int NN   = ENTNUM >> (k + 1);
      localparam bit REGD = ((PIPE_MASK >> k) & 32'd1) != 32'd0;

      logic              o_req [NN];
      logic [ENTLEN-1:0] o_ent [NN];
      logic [VALLEN-1:0] o_val [NN];
      logic              i_vld;
      logic              o_vld;

      if (k == 0) begin : g_vin_top
         assign i_vld = in_valid;
      end else begin : g_vin_prev
         assign i_vld = g_lvl[k-1].o_vld;
      end

      for (genvar j = 0; j < NN; j++) begin : g_node
         logic              a_req, b_req, m_req;
         logic [ENTLEN-1:0] a_ent, b_ent, m_ent;
         logic [VALLEN-1:0] a_val, b_val, m_val;

         if (k == 0) begin : g_leaf
            assign a_req = reqvec[2*j];
            assign a_ent = ENTLEN'(2*j);
            assign a_val = valvec[(2*j)*VALLEN +: VALLEN];
            assign b_req = reqvec[2*j+1];
            assign b_ent = ENTLEN'(2*j+1);
            assign b_val = valvec[(2*j+1)*VALLEN +: VALLEN];
         end else begin : g_inner
            assign a_req = g_lvl[k-1].o_req[2*j];
            assign a_ent = g_lvl[k-1].o_ent[2*j];
            assign a_val = g_lvl[k-1].o_val[2*j];
            assign b_req = g_lvl[k-1].o_req[2*j+1];
            assign b_ent = g_lvl[k-1].o_ent[2*j+1];
            assign b_val = g_lvl[k-1].o_val[2*j+1];
         end

         oldest_merge2 #(
            .ENTLEN (ENTLEN),
            .VALLEN (VALLEN)
         ) u_merge (
            .req_a (a_req),
            .ent_a (a_ent),
            .val_a (a_val),
            .req_b (b_req),
            .ent_b (b_ent),
            .val_b (b_val),
            .req   (m_req),
            .ent   (m_ent),
            .val   (m_val)
         );

         if (REGD) begin : g_dreg
            logic              r_req;
            logic [ENTLEN-1:0] r_ent;
            logic [VALLEN-1:0] r_val;

            // Data is don't-care once its valid bit is flushed, so only reset and stall gate it.
            always_ff @(posedge clk) begin
               if (reset) begin
                  r_req <= 1'b0;
                  r_ent <= '0;
                  r_val <= '0;
               end else if (!stall) begin
                  r_req <= m_req;
                  r_ent <= m_ent;
                  r_val <= m_val;
               end
            end

            assign o_req[j] = r_req;
            assign o_ent[j] = r_ent;
            assign o_val[j] = r_val;
         end else begin : g_dcomb
            assign o_req[j] = m_req;
            assign o_ent[j] = m_ent;
            assign o_val[j] = m_val;
         end
      end

      if (REGD) begin : g_vreg
         logic r_vld;

         // Flush outranks stall so a stalled pipe can still be emptied.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_vld <= 1'b0;
            end else if (flush) begin
               r_vld <= 1'b0;
            end else if (!stall) begin
               r_vld <= i_vld;
            end
         end

         assign o_vld = r_vld;
      end else begin : g_vcomb
         assign o_vld = i_vld;
      end
   end

   logic              root_vld;
   logic              root_req;
   logic [ENTLEN-1:0] root_ent;
   logic [VALLEN-1:0] root_val;

   assign root_req = g_lvl[LEVELS-1].o_req[0];
   assign root_ent = g_lvl[LEVELS-1].o_ent[0];
   assign root_val = g_lvl[LEVELS-1].o_val[0];

   if (LAT == 0) begin : g_nolat
      // Purely combinational build: flush masks the result in the same cycle;
      // the clock, reset and stall have nothing to act on.
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk, reset, stall};
      assign root_vld   = g_lvl[LEVELS-1].o_vld & ~flush;
   end else begin : g_lat
      assign root_vld = g_lvl[LEVELS-1].o_vld;
   end

   assign out_valid = root_vld;
   assign found     = root_vld & root_req;
   assign oldent    = found ? root_ent : '0;
   assign oldval    = found ? root_val : '0;

`ifdef OLDEST_FINDER_ONEHOT_EN
   always_comb begin
      oldgrant = '0;
      if (found) oldgrant[oldent] = 1'b1;
   end
`endif

endmodule

// File: tb/tb_oldest_finder_pipe.sv
module tb_oldest_finder_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   total = 0;
   int   bad   = 0;

   // c: ENTNUM 8, combinational
   logic c_in_valid, c_stall, c_flush, c_out_valid, c_found;
   logic [7:0]  c_reqvec;
   logic [63:0] c_valvec;
   logic [2:0]  c_oldent;
   logic [7:0]  c_oldval;
   // b: ENTNUM 8, PIPE_MASK 3'b101
   logic b_in_valid, b_stall, b_flush, b_out_valid, b_found;
   logic [7:0]  b_reqvec;
   logic [63:0] b_valvec;
   logic [2:0]  b_oldent;
   logic [7:0]  b_oldval;
   // p: ENTNUM 8, PIPE_MASK 3'b111
   logic p_in_valid, p_stall, p_flush, p_out_valid, p_found;
   logic [7:0]  p_reqvec;
   logic [63:0] p_valvec;
   logic [2:0]  p_oldent;
   logic [7:0]  p_oldval;
   // w: ENTNUM 64, PIPE_MASK 6'b100101 (three banks)
   logic w_in_valid, w_stall, w_flush, w_out_valid, w_found;
   logic [63:0]  w_reqvec;
   logic [511:0] w_valvec;
   logic [5:0]   w_oldent;
   logic [7:0]   w_oldval;
`ifdef OLDEST_FINDER_ONEHOT_EN
   logic [7:0]  c_grant, b_grant, p_grant;
   logic [63:0] w_grant;
`endif

   oldest_finder_pipe #(.ENTNUM(8), .ENTLEN(3), .VALLEN(8), .PIPE_MASK(0)) u_c (
      .clk(clk), .reset(reset), .in_valid(c_in_valid), .stall(c_stall), .flush(c_flush),
      .reqvec(c_reqvec), .valvec(c_valvec), .out_valid(c_out_valid), .found(c_found),
      .oldent(c_oldent), .oldval(c_oldval)
`ifdef OLDEST_FINDER_ONEHOT_EN
      , .oldgrant(c_grant)
`endif
   );

   oldest_finder_pipe #(.ENTNUM(8), .ENTLEN(3), .VALLEN(8), .PIPE_MASK(5)) u_b (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .stall(b_stall), .flush(b_flush),
      .reqvec(b_reqvec), .valvec(b_valvec), .out_valid(b_out_valid), .found(b_found),
      .oldent(b_oldent), .oldval(b_oldval)
`ifdef OLDEST_FINDER_ONEHOT_EN
      , .oldgrant(b_grant)
`endif
   );

   oldest_finder_pipe #(.ENTNUM(8), .ENTLEN(3), .VALLEN(8), .PIPE_MASK(7)) u_p (
      .clk(clk), .reset(reset), .in_valid(p_in_valid), .stall(p_stall), .flush(p_flush),
      .reqvec(p_reqvec), .valvec(p_valvec), .out_valid(p_out_valid), .found(p_found),
      .oldent(p_oldent), .oldval(p_oldval)
`ifdef OLDEST_FINDER_ONEHOT_EN
      , .oldgrant(p_grant)
`endif
   );

   oldest_finder_pipe #(.ENTNUM(64), .ENTLEN(6), .VALLEN(8), .PIPE_MASK(37)) u_w (
      .clk(clk), .reset(reset), .in_valid(w_in_valid), .stall(w_stall), .flush(w_flush),
      .reqvec(w_reqvec), .valvec(w_valvec), .out_valid(w_out_valid), .found(w_found),
      .oldent(w_oldent), .oldval(w_oldval)
`ifdef OLDEST_FINDER_ONEHOT_EN
      , .oldgrant(w_grant)
`endif
   );

   // Reference: scan all entries, keep the first one with the smallest key.
   function automatic void ref_oldest(input int n, input logic [63:0] rq, input logic [511:0] vv,
                                      output logic f, output logic [5:0] e, output logic [7:0] v);
      f = 1'b0;
      e = '0;
      v = '0;
      for (int i = 0; i < n; i++) begin
         if (rq[i] && (!f || vv[i*8 +: 8] < v)) begin
            f = 1'b1;
            e = 6'(i);
            v = vv[i*8 +: 8];
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      c_in_valid = 0; c_stall = 0; c_flush = 0; c_reqvec = '0; c_valvec = '0;
      b_in_valid = 0; b_stall = 0; b_flush = 0; b_reqvec = '0; b_valvec = '0;
      w_in_valid = 0; w_stall = 0; w_flush = 0; w_reqvec = '0; w_valvec = '0;
      p_in_valid = 1; p_stall = 0; p_flush = 0; p_reqvec = 8'h10; p_valvec = {8{8'h21}};
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if ({p_out_valid, p_found, p_oldent, p_oldval} !== 13'd0)
            $display("FAIL reset_hold cyc%0d: got ov=%0b f=%0b ent=%0d val=%0d, want all 0",
                     i, p_out_valid, p_found, p_oldent, p_oldval);
         if ({p_out_valid, p_found, p_oldent, p_oldval} !== 13'd0) bad++;
      end
      reset = 1'b0;
      p_in_valid = 0;
      tick();
      total++;
      if ({b_out_valid, b_found, b_oldent, b_oldval} !== 13'd0) begin
         bad++;
         $display("FAIL reset_b: got ov=%0b f=%0b ent=%0d val=%0d, want all 0", b_out_valid, b_found, b_oldent, b_oldval);
      end
      total++;
      if ({p_out_valid, p_found, p_oldent, p_oldval} !== 13'd0) begin
         bad++;
         $display("FAIL reset_p: got ov=%0b f=%0b ent=%0d val=%0d, want all 0", p_out_valid, p_found, p_oldent, p_oldval);
      end
      total++;
      if ({w_out_valid, w_found, w_oldent, w_oldval} !== 16'd0) begin
         bad++;
         $display("FAIL reset_w: got ov=%0b f=%0b ent=%0d val=%0d, want all 0", w_out_valid, w_found, w_oldent, w_oldval);
      end
   endtask

   task automatic test_comb();
      int         iv_t [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
      logic [7:0] rq_t [8] = '{8'hFF, 8'hEF, 8'h00, 8'hFF, 8'hFF, 8'h0B, 8'h80, 8'hFF};
      int         fl_t [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
      int         st_t [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
      int         ov_t [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
      int         f_t  [8] = '{1, 1, 0, 0, 1, 1, 1, 0};
      int         e_t  [8] = '{4, 6, 0, 0, 4, 1, 7, 0};
      int         v_t  [8] = '{3, 3, 0, 0, 3, 7, 10, 0};
      logic       rf, eov, ef;
      logic [5:0] re, ee;
      logic [7:0] rv, ev;
      // Entry keys 7:10 6:3 5:9 4:3 3:20 2:5 1:7 0:8
      c_valvec = {8'd10, 8'd3, 8'd9, 8'd3, 8'd20, 8'd5, 8'd7, 8'd8};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         c_in_valid = 1'(iv_t[i]);
         c_reqvec   = rq_t[i];
         c_flush    = 1'(fl_t[i]);
         c_stall    = 1'(st_t[i]);
         #1;
         total++;
         if (c_out_valid !== 1'(ov_t[i]) || c_found !== 1'(f_t[i]) ||
             c_oldent !== 3'(e_t[i]) || c_oldval !== 8'(v_t[i])) begin
            bad++;
            $display("FAIL comb_table row%0d: got ov=%0b f=%0b ent=%0d val=%0d, want ov=%0d f=%0d ent=%0d val=%0d",
                     i, c_out_valid, c_found, c_oldent, c_oldval, ov_t[i], f_t[i], e_t[i], v_t[i]);
         end
      end
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         c_in_valid = ($urandom_range(0, 3) != 0);
         c_flush    = ($urandom_range(0, 7) == 0);
         c_stall    = 1'($urandom_range(0, 1));
         c_reqvec   = 8'($urandom) & 8'($urandom | ($urandom_range(0, 1) ? 32'hFF : 32'h0));
         for (int k = 0; k < 8; k++) c_valvec[k*8 +: 8] = 8'($urandom_range(0, 7));
         ref_oldest(8, {56'd0, c_reqvec}, {448'd0, c_valvec}, rf, re, rv);
         eov = c_in_valid & ~c_flush;
         ef  = eov & rf;
         ee  = ef ? re : 6'd0;
         ev  = ef ? rv : 8'd0;
         #1;
         total++;
         if (c_out_valid !== eov || c_found !== ef || c_oldent !== ee[2:0] || c_oldval !== ev) begin
            bad++;
            $display("FAIL comb_rand it%0d: got ov=%0b f=%0b ent=%0d val=%0d, want ov=%0b f=%0b ent=%0d val=%0d",
                     i, c_out_valid, c_found, c_oldent, c_oldval, eov, ef, ee, ev);
         end
`ifdef OLDEST_FINDER_ONEHOT_EN
         total++;
         if (c_grant !== (ef ? (8'd1 << ee[2:0]) : 8'd0)) begin
            bad++;
            $display("FAIL comb_grant it%0d: got %b, want one-hot of %0d (found=%0b)", i, c_grant, ee, ef);
         end
`endif
      end
      c_in_valid = 0; c_flush = 0; c_stall = 0;
   endtask

   task automatic test_empty();
      @(negedge clk);
      b_in_valid = 1; b_reqvec = 8'h00; b_valvec = {$urandom, $urandom};
      tick();
      total++;
      if (b_out_valid !== 1'b0) begin
         bad++;
         $display("FAIL empty_early: got ov=%0b, want 0", b_out_valid);
      end
      b_in_valid = 0; b_reqvec = 8'hFF;
      tick();
      total++;
      if ({b_out_valid, b_found, b_oldent, b_oldval} !== {1'b1, 12'd0}) begin
         bad++;
         $display("FAIL empty_result: got ov=%0b f=%0b ent=%0d val=%0d, want ov=1 f=0 ent=0 val=0",
                  b_out_valid, b_found, b_oldent, b_oldval);
      end
      b_in_valid = 1; b_reqvec = 8'h24; b_valvec = {$urandom, $urandom};
      b_valvec[2*8 +: 8] = 8'd9;
      b_valvec[5*8 +: 8] = 8'd4;
      tick();
      total++;
      if (b_out_valid !== 1'b0) begin
         bad++;
         $display("FAIL empty_gap: got ov=%0b, want 0", b_out_valid);
      end
      b_in_valid = 0;
      tick();
      total++;
      if ({b_out_valid, b_found, b_oldent, b_oldval} !== {1'b1, 1'b1, 3'd5, 8'd4}) begin
         bad++;
         $display("FAIL pipe2_result: got ov=%0b f=%0b ent=%0d val=%0d, want ov=1 f=1 ent=5 val=4",
                  b_out_valid, b_found, b_oldent, b_oldval);
      end
   endtask

   task automatic test_back_to_back();
      int         iss_t [7] = '{2, 5, 7, -1, -1, -1, -1};
      int         exp_t [7] = '{-1, -1, 0, 1, 2, -1, -1};
      logic [7:0] vals  [7];
      p_stall = 0; p_flush = 0;
      for (int c = 0; c < 7; c++) begin
         vals[c] = '0;
         p_valvec = {$urandom, $urandom};
         if (iss_t[c] >= 0) begin
            p_in_valid = 1;
            p_reqvec   = 8'd1 << iss_t[c];
            vals[c]    = p_valvec[iss_t[c]*8 +: 8];
         end else begin
            p_in_valid = 0;
            p_reqvec   = 8'($urandom);
         end
         tick();
         total++;
         if (exp_t[c] < 0) begin
            if (p_out_valid !== 1'b0) begin
               bad++;
               $display("FAIL b2b cyc%0d: got ov=%0b ent=%0d, want ov=0", c, p_out_valid, p_oldent);
            end
         end else if (p_out_valid !== 1'b1 || p_found !== 1'b1 ||
                      p_oldent !== 3'(iss_t[exp_t[c]]) || p_oldval !== vals[exp_t[c]]) begin
            bad++;
            $display("FAIL b2b cyc%0d: got ov=%0b f=%0b ent=%0d val=%0d, want ov=1 f=1 ent=%0d val=%0d",
                     c, p_out_valid, p_found, p_oldent, p_oldval, iss_t[exp_t[c]], vals[exp_t[c]]);
         end
      end
   endtask

   task automatic test_stall();
      int         iss_t [12] = '{3, -1, -1, -1, -1, -1, -1, 6, -1, -1, -1, -1};
      int         st_t  [12] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0};
      int         exp_t [12] = '{-1, -1, -1, -1, 0, 0, -1, -1, -1, -1, -1, -1};
      logic [7:0] vals  [12];
      p_flush = 0;
      for (int c = 0; c < 12; c++) begin
         vals[c] = '0;
         p_stall  = 1'(st_t[c]);
         p_valvec = {$urandom, $urandom};
         if (iss_t[c] >= 0) begin
            p_in_valid = 1;
            p_reqvec   = 8'd1 << iss_t[c];
            vals[c]    = p_valvec[iss_t[c]*8 +: 8];
         end else begin
            p_in_valid = 0;
            p_reqvec   = 8'($urandom);
         end
         tick();
         total++;
         if (exp_t[c] < 0) begin
            if (p_out_valid !== 1'b0) begin
               bad++;
               $display("FAIL stall cyc%0d: got ov=%0b ent=%0d, want ov=0", c, p_out_valid, p_oldent);
            end
         end else if (p_out_valid !== 1'b1 || p_found !== 1'b1 ||
                      p_oldent !== 3'(iss_t[exp_t[c]]) || p_oldval !== vals[exp_t[c]]) begin
            bad++;
            $display("FAIL stall cyc%0d: got ov=%0b f=%0b ent=%0d val=%0d, want ov=1 f=1 ent=%0d val=%0d",
                     c, p_out_valid, p_found, p_oldent, p_oldval, iss_t[exp_t[c]], vals[exp_t[c]]);
         end
      end
      p_stall = 0;
   endtask

   task automatic test_flush();
      int         iss_t [10] = '{1, -1, 6, -1, -1, 4, -1, -1, -1, -1};
      int         st_t  [10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      int         fl_t  [10] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
      int         exp_t [10] = '{-1, -1, -1, -1, 2, -1, -1, -1, -1, -1};
      logic [7:0] vals  [10];
      for (int c = 0; c < 10; c++) begin
         vals[c] = '0;
         p_stall  = 1'(st_t[c]);
         p_flush  = 1'(fl_t[c]);
         p_valvec = {$urandom, $urandom};
         if (iss_t[c] >= 0) begin
            p_in_valid = 1;
            p_reqvec   = 8'd1 << iss_t[c];
            vals[c]    = p_valvec[iss_t[c]*8 +: 8];
         end else begin
            p_in_valid = 0;
            p_reqvec   = 8'($urandom);
         end
         tick();
         total++;
         if (exp_t[c] < 0) begin
            if (p_out_valid !== 1'b0) begin
               bad++;
               $display("FAIL flush cyc%0d: got ov=%0b ent=%0d, want ov=0", c, p_out_valid, p_oldent);
            end
         end else if (p_out_valid !== 1'b1 || p_found !== 1'b1 ||
                      p_oldent !== 3'(iss_t[exp_t[c]]) || p_oldval !== vals[exp_t[c]]) begin
            bad++;
            $display("FAIL flush cyc%0d: got ov=%0b f=%0b ent=%0d val=%0d, want ov=1 f=1 ent=%0d val=%0d",
                     c, p_out_valid, p_found, p_oldent, p_oldval, iss_t[exp_t[c]], vals[exp_t[c]]);
         end
      end
      p_stall = 0; p_flush = 0;
   endtask

   // 64 entries, three banks: results flow through a 3-slot delay line that
   // shifts when not stalled and empties on flush.
   task automatic test_random_wide();
      logic       mv [3];
      logic       mf [3];
      logic [5:0] me [3];
      logic [7:0] mval [3];
      logic       rf, eov, ef;
      logic [5:0] re, ee;
      logic [7:0] rv, ev;
      int         vmax;
      for (int s = 0; s < 3; s++) begin
         mv[s] = 0; mf[s] = 0; me[s] = '0; mval[s] = '0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         w_in_valid = ($urandom_range(0, 3) != 0);
         w_stall    = ($urandom_range(0, 4) == 0);
         w_flush    = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0:       w_reqvec = 64'd1 << $urandom_range(0, 63);
            1:       w_reqvec = {$urandom, $urandom};
            2:       w_reqvec = '1;
            default: w_reqvec = {$urandom, $urandom} & {$urandom, $urandom};
         endcase
         if ($urandom_range(0, 9) == 0) w_reqvec = '0;
         vmax = ($urandom_range(0, 1) != 0) ? 15 : 255;
         for (int k = 0; k < 64; k++) w_valvec[k*8 +: 8] = 8'($urandom_range(0, vmax));
         ref_oldest(64, w_reqvec, w_valvec, rf, re, rv);
         if (w_flush) begin
            for (int s = 0; s < 3; s++) mv[s] = 0;
         end else if (!w_stall) begin
            for (int s = 2; s > 0; s--) begin
               mv[s] = mv[s-1]; mf[s] = mf[s-1]; me[s] = me[s-1]; mval[s] = mval[s-1];
            end
            mv[0] = w_in_valid; mf[0] = rf; me[0] = re; mval[0] = rv;
         end
         tick();
         eov = mv[2];
         ef  = eov & mf[2];
         ee  = ef ? me[2] : 6'd0;
         ev  = ef ? mval[2] : 8'd0;
         total++;
         if (w_out_valid !== eov || w_found !== ef || w_oldent !== ee || w_oldval !== ev) begin
            bad++;
            $display("FAIL wide_rand cyc%0d: got ov=%0b f=%0b ent=%0d val=%0d, want ov=%0b f=%0b ent=%0d val=%0d",
                     cyc, w_out_valid, w_found, w_oldent, w_oldval, eov, ef, ee, ev);
         end
`ifdef OLDEST_FINDER_ONEHOT_EN
         total++;
         if (w_grant !== (ef ? (64'd1 << ee) : 64'd0)) begin
            bad++;
            $display("FAIL wide_grant cyc%0d: got %h, want one-hot of %0d (found=%0b)", cyc, w_grant, ee, ef);
         end
`endif
      end
      w_in_valid = 0; w_stall = 0; w_flush = 0;
   endtask

   initial begin
      test_reset();
      test_comb();
      test_empty();
      test_back_to_back();
      test_stall();
      test_flush();
      test_random_wide();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
